// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states, lane widths and lane helpers shared by
// the load/store unit and its load aligner.
package lsu_pkg;

    // Access size encodings as presented on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RESV = 2'b11;

    // Lane widths in bits.
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } lsu_state_e;

    // A request is rejected when its size is reserved or its address is not
    // naturally aligned for the size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Starting byte lane of an access: halves always start on an even lane.
    function automatic logic [1:0] lane_of(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [1:0] lane;
        case (size)
            SZ_BYTE: lane = addr_lo;
            SZ_HALF: lane = {addr_lo[1], 1'b0};
            default: lane = 2'b00;
        endcase
        return lane;
    endfunction

    // Replace only the target lane(s) of a memory word with store data.
    function automatic logic [31:0] merge_lanes(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic [15:0] wdata);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    2'd3:    res[31:24] = wdata[7:0];
                    default: res        = word;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    res[31:16] = wdata;
                end else begin
                    res[15:0] = wdata;
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half/word out of a memory word and
// sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Extract the lane and extend it to a full word.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data   = 32'h0000_0000;
        case (lane)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (size)
            SZ_BYTE: data = is_signed ? {{(WORD_W - BYTE_W){byte_s[7]}}, byte_s}
                                      : {{(WORD_W - BYTE_W){1'b0}}, byte_s};
            SZ_HALF: data = is_signed ? {{(WORD_W - HALF_W){half_s[15]}}, half_s}
                                      : {{(WORD_W - HALF_W){1'b0}}, half_s};
            SZ_WORD: data = rdata;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine in front of a word-wide
// data memory. Sub-word stores are done as read-modify-write; misaligned or
// reserved-size requests are answered with access_err and never touch memory.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        store_done,
    output logic        access_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    lsu_state_e  state_r;
    logic [1:0]  lane_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic [15:0] sub_wdata_r;
    logic [31:0] align_data_s;

    // Only one request in flight: accept new work only when idle.
    assign req_ready = (state_r == IDLE);

    lsu_load_align u_load_align (
        .rdata     (mem_read_data),
        .lane      (lane_r),
        .size      (size_r),
        .is_signed (signed_r),
        .data      (align_data_s)
    );

    // Request FSM; every memory strobe and response pulse is registered so it is
    // settled for the whole cycle in which the memory samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            lane_r         <= 2'b00;
            size_r         <= 2'b00;
            signed_r       <= 1'b0;
            sub_wdata_r    <= 16'h0000;
            load_valid     <= 1'b0;
            load_data      <= 32'h0000_0000;
            store_done     <= 1'b0;
            access_err     <= 1'b0;
            mem_addr       <= 32'h0000_0000;
            mem_write_data <= 32'h0000_0000;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            store_done <= 1'b0;
            access_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        lane_r      <= lane_of(req_size, req_addr[1:0]);
                        size_r      <= req_size;
                        signed_r    <= req_signed;
                        sub_wdata_r <= req_wdata[15:0];
                        mem_addr    <= {2'b00, req_addr[31:2]};
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            access_err <= 1'b1;
                            state_r    <= RESP;
                        end else if (!req_write) begin
                            mem_read <= 1'b1;
                            state_r  <= RD;
                        end else if (req_size == SZ_WORD) begin
                            mem_write_data <= req_wdata;
                            mem_write      <= 1'b1;
                            state_r        <= WR;
                        end else begin
                            mem_read <= 1'b1;
                            state_r  <= RMW_RD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    mem_read   <= 1'b0;
                    load_data  <= align_data_s;
                    load_valid <= 1'b1;
                    state_r    <= RESP;
                end
                RMW_RD: begin
                    mem_read       <= 1'b0;
                    mem_write_data <= merge_lanes(mem_read_data, lane_r, size_r, sub_wdata_r);
                    mem_write      <= 1'b1;
                    state_r        <= WR;
                end
                WR: begin
                    mem_write  <= 1'b0;
                    store_done <= 1'b1;
                    state_r    <= RESP;
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random requests checked against a byte-lane
// reference model of the data memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic        store_done;
    logic        access_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:15];
    logic [31:0] model_mem [0:15];
    logic        tb_we;
    logic [3:0]  tb_idx;
    logic [31:0] tb_val;
    logic [31:0] last_load;
    int          checks = 0;
    int          errors = 0;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .store_done     (store_done),
        .access_err     (access_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: samples strobes on the falling edge.
    always @(negedge clk) begin
        if (tb_we) mem[tb_idx] = tb_val;
        if (mem_read) mem_read_data = mem[mem_addr[3:0]];
        if (mem_write) mem[mem_addr[3:0]] = mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic int unsigned ref_bits(input logic [1:0] sz);
        return (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sg);
        int unsigned bits;
        int unsigned sh;
        logic [63:0] lowmask;
        logic [63:0] v;
        bits    = ref_bits(sz);
        sh      = (a % 4) * 8;
        lowmask = (64'd1 << bits) - 64'd1;
        v       = ({32'd0, word} >> sh) & lowmask;
        if (sg && v[bits-1]) v = v | ~lowmask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] wd);
        int unsigned bits;
        int unsigned sh;
        logic [63:0] lowmask;
        logic [63:0] v;
        bits    = ref_bits(sz);
        sh      = (a % 4) * 8;
        lowmask = (64'd1 << bits) - 64'd1;
        v       = ({32'd0, word} & ~(lowmask << sh)) | (({32'd0, wd} & lowmask) << sh);
        return v[31:0];
    endfunction

    // Write a memory word while the unit is idle; returns #1 after a posedge.
    task automatic poke(input int idx, input logic [31:0] val);
        tb_idx = 4'(idx);
        tb_val = val;
        tb_we  = 1'b1;
        @(negedge clk);
        #1;
        tb_we = 1'b0;
        model_mem[idx] = val;
        @(posedge clk);
        #1;
    endtask

    // Issue one request and check response kind, latency, strobes and data.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        int          n;
        int          rd_cnt;
        int          wr_cnt;
        int          idx;
        int          exp_lat;
        logic        addr_ok;
        logic        bad;
        logic [2:0]  kind;
        logic [2:0]  exp_kind;
        logic [31:0] exp_val;
        idx = int'(a[5:2]);
        bad = ref_bad(sz, a);
        if (bad) begin
            exp_kind = 3'b001;
            exp_lat  = 1;
        end else if (!w) begin
            exp_kind = 3'b100;
            exp_lat  = 2;
        end else begin
            exp_kind = 3'b010;
            exp_lat  = (sz == 2'd2) ? 2 : 3;
        end
        check({tag, " ready_before"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        n       = 0;
        rd_cnt  = 0;
        wr_cnt  = 0;
        addr_ok = 1'b1;
        kind    = 3'b000;
        while (n < 8 && kind == 3'b000) begin
            n++;
            kind = {load_valid, store_done, access_err};
            if (mem_read) rd_cnt++;
            if (mem_write) wr_cnt++;
            if ((mem_read || mem_write) && mem_addr !== {2'b00, a[31:2]}) addr_ok = 1'b0;
            if (kind == 3'b000) begin
                @(posedge clk);
                #1;
            end
        end
        check({tag, " kind"}, 32'(kind), 32'(exp_kind));
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " reads"}, 32'(rd_cnt), (!bad && (!w || sz != 2'd2)) ? 32'd1 : 32'd0);
        check({tag, " writes"}, 32'(wr_cnt), (!bad && w) ? 32'd1 : 32'd0);
        check({tag, " mem_addr"}, 32'(addr_ok), 32'd1);
        check({tag, " ready_in_resp"}, 32'(req_ready), 32'd0);
        if (!bad && !w) begin
            exp_val = ref_load(model_mem[idx], a, sz, sg);
            check({tag, " load_data"}, load_data, exp_val);
            last_load = exp_val;
        end else begin
            check({tag, " load_hold"}, load_data, last_load);
            if (!bad) model_mem[idx] = ref_store(model_mem[idx], a, sz, wd);
            check({tag, " mem_word"}, mem[idx], model_mem[idx]);
        end
        @(posedge clk);
        #1;
        check({tag, " ready_after"}, 32'(req_ready), 32'd1);
        check({tag, " pulses_after"}, 32'({load_valid, store_done, access_err}), 32'd0);
    endtask

    // Start a store, pull reset while the write strobe is up, and check memory is untouched.
    task automatic abort_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                               input int cycles, input string tag);
        int idx;
        idx        = int'(a[5:2]);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_size   = sz;
        req_signed = 1'b0;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        check({tag, " wr_strobe"}, 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check({tag, " strobes_cleared"},
              32'({mem_read, mem_write, load_valid, store_done, access_err}), 32'd0);
        check({tag, " load_data_cleared"}, load_data, 32'd0);
        check({tag, " mem_addr_cleared"}, mem_addr, 32'd0);
        check({tag, " wdata_cleared"}, mem_write_data, 32'd0);
        @(negedge clk);
        #1;
        check({tag, " mem_unchanged"}, mem[idx], model_mem[idx]);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " ready_after_reset"}, 32'(req_ready), 32'd1);
        last_load = 32'd0;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        tb_we      = 1'b0;
        tb_idx     = 4'd0;
        tb_val     = 32'd0;
        last_load  = 32'd0;
        for (int i = 0; i < 16; i++) begin
            mem[i]       = 32'd0;
            model_mem[i] = 32'd0;
        end

        // Reset state.
        #12;
        check("rst strobes", 32'({mem_read, mem_write, load_valid, store_done, access_err}), 32'd0);
        check("rst load_data", load_data, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_write_data", mem_write_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst ready_first_edge", 32'(req_ready), 32'd1);

        // Word load.
        poke(0, 32'h0000_000A);
        do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "ld_word");
        check("ld_word const", load_data, 32'h0000_000A);

        // Signed / unsigned byte loads from the top lane.
        poke(0, 32'h80FF_1234);
        do_req(1'b0, 2'd0, 1'b1, 32'h3, 32'h0, "ld_sbyte");
        check("ld_sbyte const", load_data, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b0, 32'h3, 32'h0, "ld_ubyte");
        check("ld_ubyte const", load_data, 32'h0000_0080);
        do_req(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, "ld_shalf");
        check("ld_shalf const", load_data, 32'hFFFF_80FF);

        // Byte store by read-modify-write.
        poke(1, 32'h1122_3344);
        do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_00AB, "st_byte");
        check("st_byte const", mem[1], 32'h1122_AB44);
        do_req(1'b1, 2'd1, 1'b0, 32'h6, 32'hFFFF_5A5A, "st_half");
        check("st_half const", mem[1], 32'h5A5A_AB44);

        // Rejected requests.
        do_req(1'b0, 2'd1, 1'b0, 32'h1, 32'h0, "err_half");
        do_req(1'b1, 2'd2, 1'b0, 32'h6, 32'hCAFE_F00D, "err_word_st");
        do_req(1'b0, 2'd3, 1'b0, 32'h4, 32'h0, "err_resv");

        // Reset during the write cycle of a word store and of a sub-word store.
        poke(2, 32'h0BAD_F00D);
        abort_store(2'd2, 32'h8, 32'hDEAD_BEEF, 0, "abort_word");
        poke(3, 32'h0102_0304);
        abort_store(2'd0, 32'hD, 32'h0000_00EE, 1, "abort_byte");

        // Back-to-back loads with req_valid held high.
        poke(0, 32'h1111_0000);
        poke(1, 32'h2222_0001);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        check("q ready_first", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_addr = 32'h4;
        check("q busy_rd", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("q first_valid", 32'(load_valid), 32'd1);
        check("q first_data", load_data, 32'h1111_0000);
        check("q busy_resp", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("q idle_ready", 32'(req_ready), 32'd1);
        check("q idle_no_read", 32'(mem_read), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("q second_read", 32'(mem_read), 32'd1);
        @(posedge clk);
        #1;
        check("q second_valid", 32'(load_valid), 32'd1);
        check("q second_data", load_data, 32'h2222_0001);
        last_load = 32'h2222_0001;
        @(posedge clk);
        #1;

        // Random traffic against the model.
        for (int i = 0; i < 16; i++) poke(i, $urandom);
        for (int t = 0; t < 200; t++) begin
            do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   32'($urandom_range(0, 63)), $urandom, "rnd");
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        for (int i = 0; i < 16; i++) check("final mem", mem[i], model_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on posedge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: req_valid  input  1  pipeline presents a memory request.
REQ-004 SHALL: req_ready  output  1  unit accepts a request this cycle.
REQ-005 SHALL: req_write  input  1  1 = store, 0 = load.
REQ-006 SHALL: req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL: req_signed  input  1  load sign-extends when 1; zero-extends when 0.
REQ-008 SHALL: req_addr  input  32  byte address.
REQ-009 SHALL: req_wdata  input  32  store data, right-justified.
REQ-010 SHALL: load_valid  output  1  one-cycle pulse; load_data is valid.
REQ-011 SHALL: load_data  output  32  formatted load result.
REQ-012 SHALL: store_done  output  1  one-cycle pulse; store committed.
REQ-013 SHALL: access_err  output  1  one-cycle pulse; request rejected as misaligned or reserved.
REQ-014 SHALL: mem_addr  output  32  word index to data memory, equal to {2'b00, addr[31:2]}.
REQ-015 SHALL: mem_write_data  output  32  word written to data memory.
REQ-016 SHALL: mem_write  output  1  data memory write strobe.
REQ-017 SHALL: mem_read  output  1  data memory read strobe.
REQ-018 SHALL: mem_read_data  input  32  data memory word, valid at the posedge that ends a mem_read cycle.

Function
REQ-019 SHALL: handshake occurs on req_valid & req_ready, and req_ready = (state == IDLE).
REQ-020 SHALL: on handshake, register addr, size, signed, write and wdata; later req_* changes have no effect.
REQ-021 SHALL: states are IDLE, RD, RMW_RD, WR, RESP.
REQ-022 SHALL: IDLE transitions on handshake as follows: load to RD; word store to WR; byte/half store to RMW_RD; misaligned or reserved request to RESP with an error flag.
REQ-023 SHALL: misalignment is defined as half with addr[0]=1, or word with addr[1:0]!=0, or size 11; such a request never asserts mem_read or mem_write.
REQ-024 SHALL: transitions RD->RESP, RMW_RD->WR, WR->RESP and RESP->IDLE occur unconditionally.
REQ-025 SHALL: mem_read, mem_write, mem_addr and mem_write_data are registered outputs and stay stable for the whole cycle so the memory's negedge sampling sees settled values.
REQ-026 SHALL: mem_read = 1 exactly in RD and RMW_RD; mem_write = 1 exactly in WR; both are 0 otherwise.
REQ-027 SHALL: byte lane n occupies bits [8n+7:8n] (little-endian); lane = addr[1:0] for bytes and addr[1]*2 for halves.
REQ-028 SHALL: at the posedge leaving RD, capture the lane extracted from mem_read_data, extended per req_signed, into load_data.
REQ-029 SHALL: at the posedge leaving RMW_RD, set mem_write_data to mem_read_data with only the target lane(s) replaced by wdata[7:0] or wdata[15:0].
REQ-030 SHALL: a word store drives mem_write_data = wdata in WR.
REQ-031 SHALL: RESP asserts exactly one of load_valid, store_done or access_err, for one cycle.
REQ-032 SHALL: latencies from the handshake cycle to the response pulse are load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-033 SHALL: load_data holds its value until the next load response.

Reset
REQ-034 SHALL: rst_n low immediately forces state to IDLE and clears mem_read, mem_write, load_valid, store_done, access_err, load_data, mem_addr and mem_write_data to 0.
REQ-035 SHALL: reset asserted during WR before the negedge suppresses the write; a partially performed read-modify-write leaves memory unchanged.
REQ-036 SHALL: after rst_n deasserts, req_ready = 1 on the first posedge.

Structure
REQ-037 SHALL: package lsu_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum and the lane-width constants.
REQ-038 SHALL: one sub-module, lsu_load_align, performs combinational lane extraction and sign/zero extension.

Verification
REQ-039 SHALL: word load at addr 0x0 with word0 = 0x0000000A -> mem_read high exactly 1 cycle, load_valid 2 cycles after handshake, load_data = 0x0000000A.
REQ-040 SHALL: signed byte load at addr 0x3 with word0 = 0x80FF1234 -> load_data = 0xFFFFFF80; the unsigned byte load gives 0x00000080.
REQ-041 SHALL: byte store of 0xAB at addr 0x5 with word1 = 0x11223344 -> mem_read then mem_write at mem_addr 1, memory word becomes 0x1122AB44, store_done 3 cycles after handshake.
REQ-042 SHALL: half load at addr 0x1 -> access_err 1 cycle later, mem_read and mem_write never asserted, req_ready high again 2 cycles after handshake.
REQ-043 SHALL: rst_n low during WR of a word store of 0xDEADBEEF to addr 0x8 -> mem_write drops asynchronously, word2 unchanged, all outputs 0.
REQ-044 SHALL: req_valid held high with two queued loads -> second handshake occurs only in the IDLE cycle after the first RESP.
